// File: rtl/mmcm_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// mmcm_lock_supervisor_if
//   Bundles the MMCM supervisor's status and control signals so the
//   supervisor and its environment connect through one port.
//
//   Signals
//     locked_async   MMCM LOCKED, asynchronous to the supervisor clock
//     retry_req      one-cycle pulse, restarts the sequence from FAIL
//     clr_stats      one-cycle pulse, clears lock_loss_cnt
//     mmcm_rst       MMCM RST drive
//     sys_rst        system reset request, active-high
//     lock_ok        high while the clock is qualified and running
//     fail           sticky failure flag
//     retry_cnt      consecutive lock timeouts in the current sequence
//     lock_loss_cnt  saturating count of lock losses while running
//
//   Modports
//     master  environment side: drives the inputs, observes the status
//     slave   supervisor side
// ---------------------------------------------------------------------------
interface mmcm_lock_supervisor_if;
   logic       locked_async;
   logic       retry_req;
   logic       clr_stats;
   logic       mmcm_rst;
   logic       sys_rst;
   logic       lock_ok;
   logic       fail;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   modport master (
      output locked_async,
      output retry_req,
      output clr_stats,
      input  mmcm_rst,
      input  sys_rst,
      input  lock_ok,
      input  fail,
      input  retry_cnt,
      input  lock_loss_cnt
   );

   modport slave (
      input  locked_async,
      input  retry_req,
      input  clr_stats,
      output mmcm_rst,
      output sys_rst,
      output lock_ok,
      output fail,
      output retry_cnt,
      output lock_loss_cnt
   );
endinterface

// File: rtl/mmcm_lock_supervisor.sv
// ---------------------------------------------------------------------------
// mmcm_lock_supervisor
//   Brings the MMCM up and keeps it honest. Each attempt pulses the MMCM
//   reset, waits for LOCKED, requires LOCKED to stay high for a qualification
//   window and only then releases sys_rst to the downstream reset
//   synchronisers. A lock loss while running re-arms the whole sequence; a
//   lock timeout retries, and after MAX_RETRY consecutive timeouts the block
//   parks in a sticky FAIL state until retry_req or rst_in.
//
//   Ports
//     clk_in   free-running input clock (never sourced from the MMCM)
//     rst_in   asynchronous, active-high reset
//     bus      mmcm_lock_supervisor_if.slave, see the interface for signals
//
//   Parameters
//     RST_PULSE_CYC     cycles mmcm_rst is held per attempt (>=1)
//     LOCK_TIMEOUT_CYC  cycles allowed waiting for LOCKED (<=2**CNT_W)
//     STABLE_CYC        consecutive locked cycles before release (>=1)
//     MAX_RETRY         consecutive timeouts before FAIL (1..15)
//     CNT_W             width of the shared cycle counter
// ---------------------------------------------------------------------------
module mmcm_lock_supervisor #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 65535,
   parameter int STABLE_CYC       = 200,
   parameter int MAX_RETRY        = 7,
   parameter int CNT_W            = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   mmcm_lock_supervisor_if.slave  bus
);

   // Terminal counts of the shared counter, one per timed state.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t           state_reg,     state_next;
   logic [CNT_W-1:0] cnt_reg,       cnt_next;
   logic             mmcm_rst_reg,  mmcm_rst_next;
   logic             sys_rst_reg,   sys_rst_next;
   logic             lock_ok_reg,   lock_ok_next;
   logic             fail_reg,      fail_next;
   logic [3:0]       retry_cnt_reg, retry_cnt_next;
   logic [7:0]       loss_cnt_reg,  loss_cnt_next;

   // LOCKED synchroniser: sync_reg[0] may go metastable, only sync_reg[1]
   // (locked_s) is ever looked at by the control logic.
   logic [1:0] sync_reg;
   logic       locked_s;

   assign locked_s = sync_reg[1];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], bus.locked_async};
      end
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg     <= ST_RST;
         cnt_reg       <= '0;
         mmcm_rst_reg  <= 1'b1;
         sys_rst_reg   <= 1'b1;
         lock_ok_reg   <= 1'b0;
         fail_reg      <= 1'b0;
         retry_cnt_reg <= 4'd0;
         loss_cnt_reg  <= 8'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         mmcm_rst_reg  <= mmcm_rst_next;
         sys_rst_reg   <= sys_rst_next;
         lock_ok_reg   <= lock_ok_next;
         fail_reg      <= fail_next;
         retry_cnt_reg <= retry_cnt_next;
         loss_cnt_reg  <= loss_cnt_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   logic [3:0] retry_inc;
   logic [7:0] loss_inc;

   assign retry_inc = retry_cnt_reg + 4'd1;
   // Saturating increment of the lock-loss statistic.
   assign loss_inc  = (loss_cnt_reg == 8'hff) ? 8'hff : loss_cnt_reg + 8'd1;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg + CNT_ONE;
      mmcm_rst_next  = mmcm_rst_reg;
      sys_rst_next   = sys_rst_reg;
      lock_ok_next   = lock_ok_reg;
      fail_next      = fail_reg;
      retry_cnt_next = retry_cnt_reg;
      // A lone clear takes effect here; a lock loss in the same cycle
      // overrides it below so the loss that just happened is still counted.
      loss_cnt_next  = bus.clr_stats ? 8'd0 : loss_cnt_reg;

      case (state_reg)
         ST_RST: begin
            if (cnt_reg == RST_LAST) begin
               state_next    = ST_WAIT_LOCK;
               cnt_next      = '0;
               mmcm_rst_next = 1'b0;
            end
         end

         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_next = ST_STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               cnt_next       = '0;
               retry_cnt_next = retry_inc;
               mmcm_rst_next  = 1'b1;
               if (retry_inc == RETRY_LIMIT) begin
                  state_next = ST_FAIL;
                  fail_next  = 1'b1;
               end else begin
                  state_next = ST_RST;
               end
            end
         end

         ST_STABLE: begin
            // A dropout while qualifying is treated as a glitch: go back to
            // waiting with a fresh timeout but keep the retry history.
            if (!locked_s) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == STABLE_LAST) begin
               state_next     = ST_RUN;
               cnt_next       = '0;
               sys_rst_next   = 1'b0;
               lock_ok_next   = 1'b1;
               retry_cnt_next = 4'd0;
            end
         end

         ST_RUN: begin
            cnt_next = cnt_reg;
            if (!locked_s) begin
               // sys_rst and mmcm_rst assert together on the same edge.
               state_next    = ST_RST;
               cnt_next      = '0;
               sys_rst_next  = 1'b1;
               mmcm_rst_next = 1'b1;
               lock_ok_next  = 1'b0;
               loss_cnt_next = bus.clr_stats ? 8'd1 : loss_inc;
            end
         end

         ST_FAIL: begin
            cnt_next = cnt_reg;
            if (bus.retry_req) begin
               state_next     = ST_RST;
               cnt_next       = '0;
               retry_cnt_next = 4'd0;
               fail_next      = 1'b0;
            end
         end

         default: begin
            // Unreachable encodings recover through a full reset attempt.
            state_next     = ST_RST;
            cnt_next       = '0;
            mmcm_rst_next  = 1'b1;
            sys_rst_next   = 1'b1;
            lock_ok_next   = 1'b0;
            fail_next      = 1'b0;
         end
      endcase
   end

   assign bus.mmcm_rst      = mmcm_rst_reg;
   assign bus.sys_rst       = sys_rst_reg;
   assign bus.lock_ok       = lock_ok_reg;
   assign bus.fail          = fail_reg;
   assign bus.retry_cnt     = retry_cnt_reg;
   assign bus.lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_mmcm_lock_supervisor
//   Directed bench for mmcm_lock_supervisor. The stimulus process pushes the
//   expected output tuple and the clk_in cycle at which it must appear; the
//   monitor pops one entry every time the DUT outputs change and compares.
//   Tuple layout: {mmcm_rst, sys_rst, lock_ok, fail, retry_cnt, lock_loss_cnt}.
// ---------------------------------------------------------------------------
module tb_mmcm_lock_supervisor;

   logic clk_in = 1'b0;
   logic rst_in;

   mmcm_lock_supervisor_if bus ();

   mmcm_lock_supervisor #(
      .RST_PULSE_CYC    (16),
      .LOCK_TIMEOUT_CYC (100),
      .STABLE_CYC       (200),
      .MAX_RETRY        (7),
      .CNT_W            (16)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [15:0] outs;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [15:0] obs;
   assign obs = {bus.mmcm_rst, bus.sys_rst, bus.lock_ok, bus.fail,
                 bus.retry_cnt, bus.lock_loss_cnt};

   function automatic logic [15:0] pk(int m, int s, int l, int f, int r, int c);
      return {1'(m), 1'(s), 1'(l), 1'(f), 4'(r), 8'(c)};
   endfunction

   function automatic int sat8(int k);
      return (k > 255) ? 255 : k;
   endfunction

   task automatic push(int at, logic [15:0] v, string tag);
      exp_t e;
      e.at   = at;
      e.outs = v;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(int t);
      while (cyc < t) @(negedge clk_in);
   endtask

   // Monitor: samples 1 time unit after every falling edge and after any
   // rising edge of rst_in, so asynchronous reset shows up with no clock
   // edge in between.
   initial begin
      logic [15:0] prev;
      exp_t        e;
      bit          first;
      first = 1'b1;
      prev  = '0;
      @(negedge clk_in);
      #1;
      forever begin
         if (first || obs !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e.outs || (e.at >= 0 && e.at != cyc)) begin
                  bad++;
                  $display("FAIL %s got=%h at cyc %0d required=%h at cyc %0d",
                           e.tag, obs, cyc, e.outs, e.at);
               end else begin
                  $display("ok %s cyc=%0d outs=%h", e.tag, cyc, obs);
               end
            end
            prev  = obs;
            first = 1'b0;
         end
         @(negedge clk_in or posedge rst_in);
         #1;
      end
   end

   // Stimulus
   initial begin
      int c0, c1, L, F, T, Q, F2, T1, T2, F3, S, D, P;
      rst_in            = 1'b1;
      bus.locked_async  = 1'b0;
      bus.retry_req     = 1'b0;
      bus.clr_stats     = 1'b0;
      push(-1, pk(1, 1, 0, 0, 0, 0), "reset_state");
      repeat (3) @(negedge clk_in);

      // Reset release, 16-cycle MMCM pulse, lock 5 cycles later.
      c0 = cyc;
      rst_in = 1'b0;
      push(c0 + 16, pk(0, 1, 0, 0, 0, 0), "rst_pulse_end");
      wait_until(c0 + 21);
      bus.locked_async = 1'b1;
      push(c0 + 224, pk(0, 0, 1, 0, 0, 0), "first_release");
      wait_until(c0 + 230);

      // Repeated one-cycle lock losses from RUN; counter saturates at 255.
      for (int k = 1; k <= 260; k++) begin
         L = cyc;
         bus.locked_async = 1'b0;
         push(L + 3,   pk(1, 1, 0, 0, 0, sat8(k)), "loss");
         push(L + 19,  pk(0, 1, 0, 0, 0, sat8(k)), "loss_pulse_end");
         push(L + 220, pk(0, 0, 1, 0, 0, sat8(k)), "loss_relock");
         @(negedge clk_in);
         bus.locked_async = 1'b1;
         wait_until(L + 225);
      end

      // clr_stats in the same cycle as a loss increment -> 1.
      L = cyc;
      bus.locked_async = 1'b0;
      push(L + 3,   pk(1, 1, 0, 0, 0, 1), "loss_with_clr");
      push(L + 19,  pk(0, 1, 0, 0, 0, 1), "loss_clr_pulse_end");
      push(L + 220, pk(0, 0, 1, 0, 0, 1), "loss_clr_relock");
      @(negedge clk_in);
      bus.locked_async = 1'b1;
      @(negedge clk_in);
      bus.clr_stats = 1'b1;
      @(negedge clk_in);
      bus.clr_stats = 1'b0;
      wait_until(L + 225);

      // Plain clear while running.
      P = cyc;
      bus.clr_stats = 1'b1;
      push(P + 1, pk(0, 0, 1, 0, 0, 0), "clr_stats");
      @(negedge clk_in);
      bus.clr_stats = 1'b0;
      wait_until(P + 5);

      // Permanent lock loss: seven timeouts, then FAIL.
      L = cyc;
      bus.locked_async = 1'b0;
      push(L + 3, pk(1, 1, 0, 0, 0, 1), "loss_no_relock");
      F = L + 19;
      push(F, pk(0, 1, 0, 0, 0, 1), "pulse_end_before_timeouts");
      for (int k = 1; k <= 7; k++) begin
         T = F + 116 * (k - 1) + 100;
         if (k < 7) begin
            push(T,      pk(1, 1, 0, 0, k, 1), "timeout");
            push(T + 16, pk(0, 1, 0, 0, k, 1), "retry_pulse_end");
         end else begin
            push(T, pk(1, 1, 0, 1, 7, 1), "fail_entry");
         end
      end
      // retry_req while waiting for lock must be ignored.
      wait_until(F + 50);
      bus.retry_req = 1'b1;
      @(negedge clk_in);
      bus.retry_req = 1'b0;
      wait_until(F + 796 + 10);

      // retry_req from FAIL restarts with a fresh pulse.
      Q = cyc;
      bus.retry_req = 1'b1;
      push(Q + 1,  pk(1, 1, 0, 0, 0, 1), "retry_from_fail");
      push(Q + 17, pk(0, 1, 0, 0, 0, 1), "retry_pulse_end");
      @(negedge clk_in);
      bus.retry_req = 1'b0;

      // Two more timeouts, then lock with a glitch at STABLE cnt=150.
      F2 = Q + 17;
      T1 = F2 + 100;
      push(T1,      pk(1, 1, 0, 0, 1, 1), "timeout_a");
      push(T1 + 16, pk(0, 1, 0, 0, 1, 1), "timeout_a_pulse_end");
      T2 = T1 + 116;
      push(T2,      pk(1, 1, 0, 0, 2, 1), "timeout_b");
      F3 = T2 + 16;
      push(F3,      pk(0, 1, 0, 0, 2, 1), "timeout_b_pulse_end");
      wait_until(F3 + 5);
      bus.locked_async = 1'b1;
      S = F3 + 8;
      D = S + 150;
      push(D + 204, pk(0, 0, 1, 0, 0, 1), "relock_after_glitch");
      wait_until(D);
      bus.locked_async = 1'b0;
      @(negedge clk_in);
      bus.locked_async = 1'b1;
      wait_until(D + 210);

      // Asynchronous reset while in WAIT_LOCK.
      L = cyc;
      bus.locked_async = 1'b0;
      push(L + 3,  pk(1, 1, 0, 0, 0, 2), "loss_before_wait_rst");
      push(L + 19, pk(0, 1, 0, 0, 0, 2), "pulse_end_before_wait_rst");
      wait_until(L + 30);
      #2;
      push(cyc, pk(1, 1, 0, 0, 0, 0), "async_rst_wait");
      rst_in = 1'b1;
      @(negedge clk_in);
      bus.locked_async = 1'b1;
      @(negedge clk_in);
      c1 = cyc;
      rst_in = 1'b0;
      push(c1 + 16,  pk(0, 1, 0, 0, 0, 0), "pulse_end_after_wait_rst");
      push(c1 + 217, pk(0, 0, 1, 0, 0, 0), "relock_after_wait_rst");
      wait_until(c1 + 225);

      // Asynchronous reset while in RUN.
      L = cyc;
      bus.locked_async = 1'b0;
      push(L + 3,   pk(1, 1, 0, 0, 0, 1), "loss_before_run_rst");
      push(L + 19,  pk(0, 1, 0, 0, 0, 1), "pulse_end_before_run_rst");
      push(L + 220, pk(0, 0, 1, 0, 0, 1), "relock_before_run_rst");
      @(negedge clk_in);
      bus.locked_async = 1'b1;
      wait_until(L + 225);
      #2;
      push(cyc, pk(1, 1, 0, 0, 0, 0), "async_rst_run");
      rst_in = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      c1 = cyc;
      rst_in = 1'b0;
      push(c1 + 16,  pk(0, 1, 0, 0, 0, 0), "pulse_end_after_run_rst");
      push(c1 + 217, pk(0, 0, 1, 0, 0, 0), "relock_after_run_rst");
      wait_until(c1 + 230);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_events got=%0d pending required=0 next=%s",
                  exp_q.size(), exp_q[0].tag);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
